// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
// Expected half-period tables are indexed [mon_sel][gen_speed].
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } mon_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_LONG    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Row 0 is ser_clk, row 1 is enc_clk; columns follow the divider's gen_speed encoding.
    localparam logic [7:0] EXP_HALF [2][4] = '{
        '{8'd1,  8'd4,  8'd8,  8'd2},
        '{8'd16, 8'd33, 8'd66, 8'd8}
    };

endpackage

// File: rtl/clk_edge_sync.sv
// Multi-stage synchronizer for a divided clock sampled as data, followed by a
// toggle detector that emits a one-cycle pulse on every rising or falling edge.
module clk_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures half-periods of a divided clock in local_clk cycles and reports lock or an error cause.
// Optional min/max half-period statistics are enabled with `define CLK_RATIO_MON_STATS_EN.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int N_SAMPLES   = 8,
    parameter int TOL         = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       local_clk_i,
    input  logic       rst_i,
    input  logic [1:0] gen_speed_i,
    input  logic       mon_sel_i,
    input  logic       mon_clk_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       lock_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic [7:0] last_half_o
`ifdef CLK_RATIO_MON_STATS_EN
    ,
    output logic [7:0] min_half_o,
    output logic [7:0] max_half_o
`endif
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [8:0] NSAMP_C   = 9'(N_SAMPLES);
    localparam logic [8:0] TOL_C     = 9'(TOL);

    mon_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] samp_q;
    logic [1:0] spd_q;
    logic       sel_q;
    logic       lock_q, err_q;
    logic [1:0] code_q;
    logic [7:0] last_q;

    logic       edgeSeen;
    logic [7:0] expHalf;
    logic [8:0] loBound, hiBound;
    logic       below, above, abort, timeout, lockHit;
    logic [8:0] sampNext;

    clk_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (local_clk_i),
        .rst_i (rst_i),
        .d_i   (mon_clk_i),
        .edge_o(edgeSeen)
    );

    // Window and event decode; the low bound never drops below one cycle.
    always_comb begin
        expHalf  = EXP_HALF[sel_q][spd_q];
        hiBound  = {1'b0, expHalf} + TOL_C;
        loBound  = ({1'b0, expHalf} > TOL_C) ? ({1'b0, expHalf} - TOL_C) : 9'd1;
        below    = ({1'b0, cnt_q} < loBound);
        above    = ({1'b0, cnt_q} > hiBound);
        abort    = (gen_speed_i != spd_q) || (mon_sel_i != sel_q);
        timeout  = (cnt_q >= TIMEOUT_C);
        sampNext = {1'b0, samp_q} + 9'd1;
        lockHit  = (sampNext >= NSAMP_C);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (edgeSeen) begin
            cnt_d = 8'd1;
        end else if (state_q == IDLE) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge local_clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A settings change while busy aborts silently; an edge always beats a timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = ARM;
            ARM: begin
                if (abort)         state_d = IDLE;
                else if (edgeSeen) state_d = MEAS;
                else if (timeout)  state_d = DONE;
            end
            MEAS: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (edgeSeen) begin
                    if (below || above || lockHit) state_d = DONE;
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ARM) || (state_q == MEAS);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge local_clk_i) begin
        if (!rst_i) begin
            samp_q <= 8'd0;
            spd_q  <= 2'd0;
            sel_q  <= 1'b0;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            last_q <= 8'd0;
        end else begin
            if (state_q == IDLE && start_i) begin
                samp_q <= 8'd0;
                spd_q  <= gen_speed_i;
                sel_q  <= mon_sel_i;
                lock_q <= 1'b0;
                err_q  <= 1'b0;
                code_q <= ERR_NONE;
            end else if (state_q == ARM && !abort && !edgeSeen && timeout) begin
                err_q  <= 1'b1;
                code_q <= ERR_TIMEOUT;
            end else if (state_q == MEAS && !abort) begin
                if (edgeSeen) begin
                    last_q <= cnt_q;
                    if (below) begin
                        err_q  <= 1'b1;
                        code_q <= ERR_SHORT;
                    end else if (above) begin
                        err_q  <= 1'b1;
                        code_q <= ERR_LONG;
                    end else begin
                        samp_q <= sampNext[7:0];
                        if (lockHit) lock_q <= 1'b1;
                    end
                end else if (timeout) begin
                    err_q  <= 1'b1;
                    code_q <= ERR_TIMEOUT;
                end
            end
        end
    end

    assign lock_o      = lock_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign last_half_o = last_q;

`ifdef CLK_RATIO_MON_STATS_EN
    logic [7:0] min_q, max_q;

    always_ff @(posedge local_clk_i) begin
        if (!rst_i) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (state_q == IDLE && start_i) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (state_q == MEAS && !abort && edgeSeen) begin
            if (cnt_q < min_q) min_q <= cnt_q;
            if (cnt_q > max_q) max_q <= cnt_q;
        end
    end

    assign min_half_o = min_q;
    assign max_half_o = max_q;
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed, table-driven bench for clk_ratio_monitor with hand-written corner sequences.
module tb_clk_ratio_monitor;

    logic       clock = 1'b0;
    logic       rst;
    logic [1:0] genSpeed;
    logic       monSel;
    logic       monClk;
    logic       start;
    logic       busy, done, lock, err;
    logic [1:0] errCode;
    logic [7:0] lastHalf;
`ifdef CLK_RATIO_MON_STATS_EN
    logic [7:0] minHalf, maxHalf;
`endif

    int  nChecks = 0;
    int  nFails  = 0;
    bit  monRun  = 1'b0;
    int  halfPer = 4;
    int  monCnt  = 0;

    always #5 clock = ~clock;

    clk_ratio_monitor dut (
        .local_clk_i(clock),
        .rst_i      (rst),
        .gen_speed_i(genSpeed),
        .mon_sel_i  (monSel),
        .mon_clk_i  (monClk),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .lock_o     (lock),
        .err_o      (err),
        .err_code_o (errCode),
        .last_half_o(lastHalf)
`ifdef CLK_RATIO_MON_STATS_EN
        ,
        .min_half_o (minHalf),
        .max_half_o (maxHalf)
`endif
    );

    // Ideal divided clock: toggles every halfPer local cycles while running, else held low.
    always @(negedge clock) begin
        if (monRun) begin
            monCnt = monCnt + 1;
            if (monCnt >= halfPer) begin
                monClk = ~monClk;
                monCnt = 0;
            end
        end else begin
            monClk = 1'b0;
            monCnt = 0;
        end
    end

    typedef struct {
        logic       sel;
        logic [1:0] spd;
        int         hp;
        logic       expLock;
        logic       expErr;
        logic [1:0] expCode;
        logic [7:0] expLast;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [1:0] spd, input int hp);
        monSel  = sel;
        genSpeed = spd;
        halfPer = hp;
        monRun  = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 1;
        while (!got && cycles < bound) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clock);
                cycles++;
            end
        end
    endtask

    initial begin
        bit got;
        int cyc, cyc2;
        bit sawBusy, sawDone;

        vecs[0] = '{1'b0, 2'd1, 4,  1'b1, 1'b0, 2'd0, 8'd4};
        vecs[1] = '{1'b1, 2'd2, 66, 1'b1, 1'b0, 2'd0, 8'd66};
        vecs[2] = '{1'b1, 2'd0, 16, 1'b1, 1'b0, 2'd0, 8'd16};
        vecs[3] = '{1'b1, 2'd3, 8,  1'b1, 1'b0, 2'd0, 8'd8};
        vecs[4] = '{1'b1, 2'd1, 30, 1'b0, 1'b1, 2'd1, 8'd30};
        vecs[5] = '{1'b0, 2'd2, 10, 1'b0, 1'b1, 2'd2, 8'd10};
        vecs[6] = '{1'b0, 2'd0, 1,  1'b1, 1'b0, 2'd0, 8'd1};
        vecs[7] = '{1'b0, 2'd3, 3,  1'b1, 1'b0, 2'd0, 8'd3};
        vecs[8] = '{1'b0, 2'd1, 6,  1'b0, 1'b1, 2'd2, 8'd6};
        vecs[9] = '{1'b1, 2'd1, 32, 1'b1, 1'b0, 2'd0, 8'd32};

        rst      = 1'b0;
        genSpeed = 2'd0;
        monSel   = 1'b0;
        start    = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstLock", lock, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstCode", errCode, 0);
        checkOutput("rstLast", lastHalf, 0);
        rst = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].spd, vecs[i].hp);
            pulseStart();
            waitDone(20 * vecs[i].hp + 300, got, cyc);
            checkOutput($sformatf("v%0d_done", i), got, 1);
            checkOutput($sformatf("v%0d_lock", i), lock, vecs[i].expLock);
            checkOutput($sformatf("v%0d_err", i), err, vecs[i].expErr);
            checkOutput($sformatf("v%0d_code", i), errCode, vecs[i].expCode);
            checkOutput($sformatf("v%0d_last", i), lastHalf, vecs[i].expLast);
            @(negedge clock);
            checkOutput($sformatf("v%0d_donePulse", i), done, 0);
        end

        // Held-low mon_clk must time out.
        monRun = 1'b0;
        monSel = 1'b0;
        genSpeed = 2'd1;
        repeat (10) @(negedge clock);
        pulseStart();
        waitDone(400, got, cyc);
        checkOutput("toDone", got, 1);
        checkOutput("toLatencyOk", (cyc >= 255 && cyc <= 262), 1);
        checkOutput("toErr", err, 1);
        checkOutput("toCode", errCode, 3);
        checkOutput("toLock", lock, 0);
        @(negedge clock);

        // A second start while busy must not restart the measurement.
        applyStimulus(1'b0, 2'd1, 4);
        pulseStart();
        repeat (19) @(negedge clock);
        checkOutput("ignBusy", busy, 1);
        pulseStart();
        waitDone(80, got, cyc2);
        cyc = 21 + cyc2 - 1;
        checkOutput("ignDone", got, 1);
        checkOutput("ignLatencyOk", (cyc <= 48), 1);
        checkOutput("ignLock", lock, 1);
        checkOutput("ignLast", lastHalf, 4);
        sawBusy = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("ignNoRestart", sawBusy, 0);

        // Changing gen_speed mid-measurement aborts with no done pulse.
        applyStimulus(1'b0, 2'd1, 4);
        pulseStart();
        repeat (20) @(negedge clock);
        checkOutput("abBusyBefore", busy, 1);
        genSpeed = 2'd2;
        @(negedge clock);
        checkOutput("abBusy", busy, 0);
        checkOutput("abLock", lock, 0);
        checkOutput("abErr", err, 0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("abNoDone", sawDone, 0);
        genSpeed = 2'd1;

        // Reset in the middle of a measurement.
        applyStimulus(1'b1, 2'd2, 66);
        pulseStart();
        repeat (250) @(negedge clock);
        checkOutput("mrBusyBefore", busy, 1);
        checkOutput("mrLastBefore", lastHalf, 66);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("mrBusy", busy, 0);
        checkOutput("mrDone", done, 0);
        checkOutput("mrLock", lock, 0);
        checkOutput("mrErr", err, 0);
        checkOutput("mrCode", errCode, 0);
        checkOutput("mrLast", lastHalf, 0);
        rst = 1'b1;
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
- Checks the clock_div outputs (ser_clk or enc_clk) in the local_clk domain.
- The selected divided clock is treated as a data input: synchronized, edge-detected, and its half-period measured in local_clk cycles.
- Each measured half-period is compared with the expected value for the current gen_speed.
- Reports lock, or an error with a cause code. Used in bring-up and as a runtime health check beside the clock divider.

Parameters:
- N_SAMPLES, 8: consecutive in-tolerance half-periods required for lock (1..255).
- TOL, 1: allowed ± deviation in local_clk cycles.
- SYNC_STAGES, 2: synchronizer depth on mon_clk (≥2).
- TIMEOUT, 255: max cycles without a mon_clk edge before a timeout error (≤255).

Ports:
- local_clk, input, 1: single clock for the whole block.
- rst, input, 1: reset; synchronous, active-low.
- gen_speed, input, 2: speed setting, same encoding as the clock divider.
- mon_sel, input, 1: 0 = monitor ser_clk, 1 = monitor enc_clk.
- mon_clk, input, 1: selected divided clock, sampled as data.
- start, input, 1: one-cycle request to begin a measurement.
- busy, output, 1: high while in ARM or MEAS.
- done, output, 1: one-cycle pulse when a measurement completes.
- lock, output, 1: last measurement passed.
- err, output, 1: last measurement failed.
- err_code, output, 2: 0 none, 1 short, 2 long, 3 timeout.
- last_half, output, 8: most recently captured half-period.

Behaviour:
- Reset (rst=0 at a local_clk edge): state IDLE; busy, done, lock, err = 0; err_code = 0; last_half = 0; counter = 0; synchronizer flops = 0.
- Edge detection: an edge is any toggle of the synchronized mon_clk versus its previous sample. Synchronization adds SYNC_STAGES+1 cycles of latency but leaves edge spacing unchanged.
- Half-period counter (8 bits, saturates at 255):
  - loaded with 1 on the cycle an edge is detected;
  - otherwise increments.
  - At an edge, captured value = the counter value before the load = distance between edges.
- Expected half-periods, ser_clk: gen_speed 0 → 1, 1 → 4, 2 → 8, 3 → 2.
- Expected half-periods, enc_clk: gen_speed 0 → 16, 1 → 33, 2 → 66, 3 → 8.
- Tolerance window: [exp−TOL, exp+TOL]. Lower bound clamps at 1.
- FSM:
  - IDLE: start → ARM. At the same time clear lock, err and err_code, latch gen_speed/mon_sel, zero the sample count.
  - ARM: discard the first edge, then → MEAS with the counter loaded to 1. If the counter reaches TIMEOUT: err=1, code 3 → DONE.
  - MEAS, on each edge: last_half ← captured value.
    - Below the window: err=1, code 1 → DONE.
    - Above the window: err=1, code 2 → DONE.
    - Otherwise sample count +1; reaching N_SAMPLES sets lock=1 → DONE.
  - MEAS, no edge for TIMEOUT cycles: code 3 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start while busy is ignored.
- gen_speed or mon_sel differs from the latched value while busy: abort to IDLE in the same cycle. No done pulse; lock and err stay 0.
- lock and err hold in IDLE until the next accepted start or reset. They are never both 1.
- Edge and timeout in the same cycle: the edge wins.
- Reset mid-measurement: immediate return to reset values at the next clock edge.

Optional Feature:
- Macro: CLK_RATIO_MON_STATS_EN. When defined, adds two outputs:
  - min_half [7:0] and max_half [7:0], cleared to 0xFF and 0x00 on accepted start;
  - updated with every captured half-period in MEAS, including the failing one.
- When undefined: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Package clk_mon_pkg holds:
  - state enum (IDLE, ARM, MEAS, DONE);
  - err_code constants (ERR_NONE, ERR_SHORT, ERR_LONG, ERR_TIMEOUT);
  - expected half-period tables indexed [mon_sel][gen_speed].
- One sub-module, clk_edge_sync: SYNC_STAGES synchronizer plus toggle detector, outputting a one-cycle edge pulse.

Test Plan:
- Ideal ser_clk, mon_sel=0, gen_speed=1 (toggle every 4 cycles), start → done within about 45 cycles; lock=1, err=0, last_half=4.
- Ideal enc_clk, mon_sel=1, gen_speed=2 (half-period 66), N_SAMPLES=8 → lock=1, last_half=66; also cover gen_speed 0 (16) and gen_speed 3 (8).
- enc_clk half-period 30 with gen_speed=1 (expected 33, TOL=1) → err=1, err_code=1, last_half=30, lock=0.
- ser_clk half-period 10 with gen_speed=2 (expected 8) → err_code=2, last_half=10.
- mon_clk held at 0 → done 255 cycles after start (plus synchronizer latency); err_code=3.
- Change gen_speed 1→2 mid-MEAS → busy drops next cycle, no done, lock=0. A second start while busy is ignored. rst=0 mid-MEAS → all outputs return to their reset values.
